// File: rtl/laser310_pkg.sv
// ---------------------------------------------------------------------------
// laser310_pkg : shared constants and FSM encoding for the expansion SRAM arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package laser310_pkg;

    localparam logic [4:0] EXP_WIN_LO    = 5'h17;   // B800h: lowest 2K page of the window
    localparam logic [4:0] FIXED_PAGE    = 5'h17;   // page always mapped to physical bank 0
    localparam logic [3:0] BANK_PORT_DEF = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WE    = 2'd2,
        ST_HOLD  = 2'd3
    } arb_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/exp_ram_arbiter_sync2.sv
// ---------------------------------------------------------------------------
// sync2 : two-flop synchroniser for asynchronous Z80 strobes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync2 #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/exp_ram_arbiter.sv
// ---------------------------------------------------------------------------
// exp_ram_arbiter : shares the 64K expansion SRAM between the banked Z80 window and a loader port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module exp_ram_arbiter
    import laser310_pkg::*;
#(
    parameter int         RAM_AW       = 16,
    parameter int         SETUP_CYCLES = 1,
    parameter int         WE_CYCLES    = 2,
    parameter logic [1:0] BANK_RESET   = 2'b01,
    parameter logic [3:0] BANK_PORT    = BANK_PORT_DEF
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic [15:0]       Z80_A,
    input  logic [3:0]        AddrIO,
    input  logic              MREQ_N,
    input  logic              IORQ_N,
    input  logic              RD_N,
    input  logic              WR_N,
    input  logic [1:0]        D1D0,
    input  logic              ld_valid,
    input  logic [RAM_AW-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic [RAM_AW-1:0] RAM_ADDR,
    output logic [7:0]        RAM_DOUT,
    output logic              RAM_DOE,
    output logic              RAM_CS_N,
    output logic              RAM_OE_N,
    output logic              RAM_WE_N,
    output logic              WAIT_N,
    output logic [1:0]        bank
);

    localparam int               c_CW       = $clog2(max2(SETUP_CYCLES, WE_CYCLES)) + 1;
    localparam logic [c_CW-1:0]  c_SETUP_LD = c_CW'(SETUP_CYCLES - 1);
    localparam logic [c_CW-1:0]  c_WE_LD    = c_CW'(WE_CYCLES - 1);

    logic [3:0]        w_s;
    logic              w_s_mreq_n, w_s_iorq_n, w_s_rd_n, w_s_wr_n;
    arb_state_t        r_state, w_state_nxt;
    logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
    logic [RAM_AW-1:0] r_addr;
    logic [7:0]        r_data;
    logic [1:0]        r_bank;
    logic              r_iow_prev;
    logic              w_iow_lvl;
    logic              w_accept;
    logic              w_hit_raw, w_hit;
    logic [15:0]       w_z80_addr;

    sync2 #(.WIDTH(4), .RST_VAL(4'hF)) u_sync (
        .clk (clk),
        .rst (RESET),
        .i_d ({MREQ_N, IORQ_N, RD_N, WR_N}),
        .o_q (w_s)
    );

    assign {w_s_mreq_n, w_s_iorq_n, w_s_rd_n, w_s_wr_n} = w_s;

    // Bank register: update only on the entry edge of an I/O write so one OUT gives one update.
    assign w_iow_lvl = !w_s_iorq_n & !w_s_wr_n;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_bank     <= BANK_RESET;
            r_iow_prev <= 1'b0;
        end else begin
            r_iow_prev <= w_iow_lvl;
            if (w_iow_lvl && !r_iow_prev && w_s_mreq_n && w_s_rd_n && (AddrIO == BANK_PORT))
                r_bank <= D1D0;
        end
    end

    assign bank = r_bank;

    assign w_hit_raw  = !MREQ_N & IORQ_N & (Z80_A[15:11] >= EXP_WIN_LO);
    assign w_hit      = w_hit_raw & (RD_N ^ WR_N);
    assign w_z80_addr = {(Z80_A[15:11] == FIXED_PAGE) ? 2'b00 : r_bank, Z80_A[13:0]};

    // Z80 has priority: a low MREQ_N, raw or synchronised, holds the loader off.
    assign w_accept = (r_state == ST_IDLE) & ld_valid & w_s_mreq_n & MREQ_N & !RESET;
    assign ld_ready = w_accept;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_addr <= ld_addr;
                r_data <= ld_data;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = c_SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_WE;
                    w_cnt_nxt   = c_WE_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_WE: begin
                if (r_cnt == '0)
                    w_state_nxt = ST_HOLD;
                else
                    w_cnt_nxt = r_cnt - 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        RAM_ADDR = RAM_AW'(w_z80_addr);
        RAM_DOE  = 1'b0;
        RAM_CS_N = !w_hit;
        RAM_OE_N = !(w_hit & !RD_N);
        RAM_WE_N = !(w_hit & !WR_N);
        if (r_state != ST_IDLE) begin
            RAM_ADDR = r_addr;
            RAM_DOE  = 1'b1;
            RAM_CS_N = 1'b0;
            RAM_OE_N = 1'b1;
            RAM_WE_N = (r_state != ST_WE);
        end
    end

    assign RAM_DOUT = r_data;
    assign WAIT_N   = !((r_state != ST_IDLE) & w_hit_raw);

endmodule

`default_nettype wire

// File: tb/tb_exp_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_exp_ram_arbiter : directed self-checking bench for the expansion SRAM arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_exp_ram_arbiter;

    localparam int SETUP_CYCLES = 1;
    localparam int WE_CYCLES    = 2;

    logic        clk;
    logic        RESET;
    logic [15:0] Z80_A;
    logic [3:0]  AddrIO;
    logic        MREQ_N, IORQ_N, RD_N, WR_N;
    logic [1:0]  D1D0;
    logic        ld_valid;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic [15:0] RAM_ADDR;
    logic [7:0]  RAM_DOUT;
    logic        RAM_DOE, RAM_CS_N, RAM_OE_N, RAM_WE_N, WAIT_N;
    logic [1:0]  bank;

    int n_checks = 0;
    int n_pass   = 0;

    exp_ram_arbiter #(
        .RAM_AW       (16),
        .SETUP_CYCLES (SETUP_CYCLES),
        .WE_CYCLES    (WE_CYCLES),
        .BANK_RESET   (2'b01),
        .BANK_PORT    (4'b0111)
    ) dut (
        .clk      (clk),
        .RESET    (RESET),
        .Z80_A    (Z80_A),
        .AddrIO   (AddrIO),
        .MREQ_N   (MREQ_N),
        .IORQ_N   (IORQ_N),
        .RD_N     (RD_N),
        .WR_N     (WR_N),
        .D1D0     (D1D0),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .RAM_ADDR (RAM_ADDR),
        .RAM_DOUT (RAM_DOUT),
        .RAM_DOE  (RAM_DOE),
        .RAM_CS_N (RAM_CS_N),
        .RAM_OE_N (RAM_OE_N),
        .RAM_WE_N (RAM_WE_N),
        .WAIT_N   (WAIT_N),
        .bank     (bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic z80_idle();
        MREQ_N = 1'b1; IORQ_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (bank !== 2'b01) $display("FAIL reset_bank: got %b want 01", bank); else n_pass++;
        n_checks++; if ({RAM_CS_N, RAM_OE_N, RAM_WE_N} !== 3'b111) $display("FAIL reset_strobes: got %b want 111", {RAM_CS_N, RAM_OE_N, RAM_WE_N}); else n_pass++;
        n_checks++; if ({WAIT_N, ld_ready, RAM_DOE} !== 3'b100) $display("FAIL reset_wait_rdy_doe: got %b want 100", {WAIT_N, ld_ready, RAM_DOE}); else n_pass++;
        repeat (2) @(posedge clk);
        #1 RESET = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_z80_read();
        @(posedge clk); #1;
        MREQ_N = 1'b0; RD_N = 1'b0; Z80_A = 16'hC123;
        #1;
        n_checks++; if (RAM_ADDR !== 16'h4123) $display("FAIL rd_C123_addr: got %h want 4123", RAM_ADDR); else n_pass++;
        n_checks++; if ({RAM_CS_N, RAM_OE_N, RAM_WE_N} !== 3'b001) $display("FAIL rd_C123_strobes: got %b want 001", {RAM_CS_N, RAM_OE_N, RAM_WE_N}); else n_pass++;
        Z80_A = 16'hBA00; #1;
        n_checks++; if (RAM_ADDR !== 16'h3A00) $display("FAIL rd_BA00_addr: got %h want 3A00", RAM_ADDR); else n_pass++;
        Z80_A = 16'h8000; #1;
        n_checks++; if (RAM_CS_N !== 1'b1) $display("FAIL rd_8000_cs: got %b want 1", RAM_CS_N); else n_pass++;
        Z80_A = 16'hC000; RD_N = 1'b1; WR_N = 1'b0; #1;
        n_checks++; if ({RAM_ADDR, RAM_CS_N, RAM_OE_N, RAM_WE_N, RAM_DOE} !== {16'h4000, 4'b0100}) $display("FAIL wr_C000: got %h %b want 4000 0100", RAM_ADDR, {RAM_CS_N, RAM_OE_N, RAM_WE_N, RAM_DOE}); else n_pass++;
        z80_idle();
        repeat (3) @(posedge clk);
    endtask

    task automatic test_bank_write();
        @(posedge clk); #1;
        AddrIO = 4'b0111; D1D0 = 2'b11; IORQ_N = 1'b0; WR_N = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (bank !== 2'b11) $display("FAIL bank_out70: got %b want 11", bank); else n_pass++;
        D1D0 = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bank !== 2'b11) $display("FAIL bank_single_update: got %b want 11", bank); else n_pass++;
        z80_idle();
        repeat (3) @(posedge clk);
        #1;
        MREQ_N = 1'b0; RD_N = 1'b0; Z80_A = 16'hC000; #1;
        n_checks++; if (RAM_ADDR !== 16'hC000) $display("FAIL rd_C000_bank3: got %h want C000", RAM_ADDR); else n_pass++;
        z80_idle();
        @(posedge clk); #1;
        AddrIO = 4'b0110; D1D0 = 2'b00; IORQ_N = 1'b0; WR_N = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (bank !== 2'b11) $display("FAIL bank_port60: got %b want 11", bank); else n_pass++;
        z80_idle();
        repeat (3) @(posedge clk);
    endtask

    task automatic test_loader();
        int rdy_cnt, rdy_cyc, we_cnt, we_first, bad;
        rdy_cnt = 0; rdy_cyc = -1; we_cnt = 0; we_first = -1; bad = 0;
        @(posedge clk); #1;
        ld_addr = 16'h1234; ld_data = 8'hA5; ld_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ld_ready === 1'b1) begin rdy_cnt++; rdy_cyc = c; end
            if (RAM_WE_N === 1'b0) begin
                if (we_cnt == 0) we_first = c;
                we_cnt++;
                if (RAM_ADDR !== 16'h1234 || RAM_DOUT !== 8'hA5 || RAM_DOE !== 1'b1 || RAM_CS_N !== 1'b0) bad++;
            end
            @(posedge clk); #1;
            if (rdy_cnt > 0) ld_valid = 1'b0;
        end
        n_checks++; if (rdy_cnt !== 1) $display("FAIL ld_ready_pulses: got %0d want 1", rdy_cnt); else n_pass++;
        n_checks++; if (we_cnt !== WE_CYCLES) $display("FAIL ld_we_width: got %0d want %0d", we_cnt, WE_CYCLES); else n_pass++;
        n_checks++; if (we_first !== rdy_cyc + 1 + SETUP_CYCLES) $display("FAIL ld_we_latency: got %0d want %0d", we_first, rdy_cyc + 1 + SETUP_CYCLES); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL ld_bus_values: got %0d bad cycles want 0", bad); else n_pass++;
        n_checks++; if ({RAM_CS_N, RAM_DOE} !== 2'b10) $display("FAIL ld_back_idle: got %b want 10", {RAM_CS_N, RAM_DOE}); else n_pass++;
    endtask

    task automatic test_wait();
        bit found;
        int wait_lo, we_lo;
        found = 0; wait_lo = 0; we_lo = 0;
        @(posedge clk); #1;
        ld_addr = 16'hFFFF; ld_data = 8'h5A; ld_valid = 1'b1;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (RAM_WE_N === 1'b0) found = 1;
        end
        n_checks++;
        if (!found) begin
            $display("FAIL wait_we_timeout: got no WE_N low want WE_N low");
        end else begin
            n_pass++;
            we_lo = 1;
            MREQ_N = 1'b0; RD_N = 1'b0; Z80_A = 16'hB800;
            #1;
            n_checks++; if (WAIT_N !== 1'b0) $display("FAIL wait_asserted: got %b want 0", WAIT_N); else n_pass++;
            n_checks++; if ({RAM_ADDR, RAM_OE_N} !== {16'hFFFF, 1'b1}) $display("FAIL wait_z80_ignored: got %h %b want FFFF 1", RAM_ADDR, RAM_OE_N); else n_pass++;
            found = 0;
            for (int c = 0; c < 10 && !found; c++) begin
                @(posedge clk); #1;
                if (WAIT_N === 1'b1) found = 1;
                else begin
                    wait_lo++;
                    if (RAM_WE_N === 1'b0) we_lo++;
                end
            end
            n_checks++; if (wait_lo !== 2) $display("FAIL wait_length: got %0d want 2", wait_lo); else n_pass++;
            n_checks++; if (we_lo !== WE_CYCLES) $display("FAIL wait_we_width: got %0d want %0d", we_lo, WE_CYCLES); else n_pass++;
            n_checks++; if ({RAM_ADDR, RAM_CS_N, RAM_OE_N, RAM_DOE} !== {16'h3800, 3'b000}) $display("FAIL wait_z80_proceeds: got %h %b want 3800 000", RAM_ADDR, {RAM_CS_N, RAM_OE_N, RAM_DOE}); else n_pass++;
        end
        z80_idle();
        repeat (4) @(posedge clk);
    endtask

    task automatic test_priority();
        int seen, k;
        seen = 0; k = -1;
        @(posedge clk); #1;
        MREQ_N = 1'b0; RD_N = 1'b0; Z80_A = 16'h0000;
        ld_addr = 16'h0042; ld_data = 8'h11; ld_valid = 1'b1;
        #1;
        n_checks++; if (ld_ready !== 1'b0) $display("FAIL prio_same_cycle: got %b want 0", ld_ready); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ld_ready === 1'b1) seen++;
        end
        n_checks++; if (seen !== 0) $display("FAIL prio_blocked: got %0d pulses want 0", seen); else n_pass++;
        @(posedge clk); #1;
        MREQ_N = 1'b1; RD_N = 1'b1;
        #1;
        n_checks++; if (ld_ready !== 1'b0) $display("FAIL prio_sync_block: got %b want 0", ld_ready); else n_pass++;
        for (int c = 0; c < 8 && k < 0; c++) begin
            @(negedge clk);
            if (ld_ready === 1'b1) k = c;
        end
        n_checks++; if (k !== 2) $display("FAIL prio_accept_delay: got %0d want 2", k); else n_pass++;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic test_reset_in_we();
        bit found;
        int bad;
        found = 0; bad = 0;
        @(posedge clk); #1;
        ld_addr = 16'h0100; ld_data = 8'h77; ld_valid = 1'b1;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (RAM_WE_N === 1'b0) found = 1;
        end
        n_checks++;
        if (!found) $display("FAIL rst_we_timeout: got no WE_N low want WE_N low");
        else n_pass++;
        #2 RESET = 1'b1;
        #1;
        n_checks++; if ({RAM_WE_N, RAM_CS_N, RAM_DOE} !== 3'b110) $display("FAIL rst_async_strobes: got %b want 110", {RAM_WE_N, RAM_CS_N, RAM_DOE}); else n_pass++;
        n_checks++; if ({bank, WAIT_N, ld_ready} !== 4'b0110) $display("FAIL rst_async_misc: got %b want 0110", {bank, WAIT_N, ld_ready}); else n_pass++;
        @(posedge clk); #1;
        RESET = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (RAM_WE_N !== 1'b1 || ld_ready !== 1'b0 || RAM_CS_N !== 1'b1) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL rst_stays_idle: got %0d bad cycles want 0", bad); else n_pass++;
    endtask

    initial begin
        RESET = 1'b1;
        z80_idle();
        Z80_A = 16'h0000; AddrIO = 4'h0; D1D0 = 2'b00;
        ld_valid = 1'b0; ld_addr = 16'h0000; ld_data = 8'h00;
        test_reset();
        test_z80_read();
        test_bank_write();
        test_loader();
        test_wait();
        test_priority();
        test_reset_in_we();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
